// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// End-of-test checker that snoops the CPU register-file write-back port.
// It shadows the test-number and result GPRs. A write of 1 to the done GPR
// starts a settle window, after which the result is judged pass or fail.
// A watchdog declares a timeout if done never arrives. Every verdict is
// sticky until reset.

module riscv_test_monitor #(
   parameter int unsigned SETTLE_CYCLES  = 10,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned DONE_REG       = 26,
   parameter int unsigned RESULT_REG     = 27,
   parameter int unsigned TESTNUM_REG    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [31:0] test_num,
   output logic [31:0] cycle_cnt
);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SETTLE,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } state_t;

   localparam logic [4:0]  DONE_ADDR    = 5'(DONE_REG);
   localparam logic [4:0]  RESULT_ADDR  = 5'(RESULT_REG);
   localparam logic [4:0]  TESTNUM_ADDR = 5'(TESTNUM_REG);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] test_num_q, test_num_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] result_q, result_d;
   logic [31:0] settle_cnt_q, settle_cnt_d;

   logic        snoop_active;
   logic        wr_valid;
   logic        wr_testnum;
   logic        wr_result;
   logic        wr_done_one;
   logic [31:0] result_now;

   // Decode the write-back port and compute the next state of every tracker.
   always_comb begin
      state_d      = state_q;
      test_num_d   = test_num_q;
      cycle_cnt_d  = cycle_cnt_q;
      result_d     = result_q;
      settle_cnt_d = settle_cnt_q;

      snoop_active = (state_q == ST_RUN) || (state_q == ST_SETTLE);
      wr_valid     = wb_we && (wb_waddr != 5'd0);
      wr_testnum   = wr_valid && (wb_waddr == TESTNUM_ADDR);
      wr_result    = wr_valid && (wb_waddr == RESULT_ADDR);
      wr_done_one  = wr_valid && (wb_waddr == DONE_ADDR) && (wb_wdata == 32'd1);
      result_now   = wr_result ? wb_wdata : result_q;

      if (snoop_active) begin
         if (cycle_cnt_q != 32'hFFFF_FFFF) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
         end
         if (wr_testnum) begin
            test_num_d = wb_wdata;
         end
         if (wr_result) begin
            result_d = wb_wdata;
         end
      end

      case (state_q)
         ST_RUN: begin
            if (wr_done_one) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = 32'd0;
            end else if (cycle_cnt_q == TIMEOUT_LAST) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_SETTLE: begin
            settle_cnt_d = settle_cnt_q + 32'd1;
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = (result_now == 32'd1) ? ST_PASS : ST_FAIL;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // State and shadow registers; reset restarts monitoring from RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         test_num_q   <= 32'd0;
         cycle_cnt_q  <= 32'd0;
         result_q     <= 32'd0;
         settle_cnt_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         test_num_q   <= test_num_d;
         cycle_cnt_q  <= cycle_cnt_d;
         result_q     <= result_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
   assign pass      = (state_q == ST_PASS);
   assign fail      = (state_q == ST_FAIL);
   assign timeout   = (state_q == ST_TIMEOUT);
   assign test_num  = test_num_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Testbench for riscv_test_monitor.
// Scenario vectors go through a common runner. The expected verdict of each
// vector is queued when its stimulus starts and is popped when done rises.

module tb_riscv_test_monitor;

   localparam int SETTLE  = 10;
   localparam int TIMEOUT = 50;
   localparam int MAX_STEPS = 80;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [31:0] test_num;
   logic [31:0] cycle_cnt;

   int checks;
   int errors;
   int curVec;

   typedef struct {
      int unsigned testNum;
      int unsigned earlyRes;
      bit          doDone;
      int          doneStep;
      int          lateOff;
      int unsigned lateVal;
      bit          expPass;
      bit          expFail;
      bit          expTimeout;
      int          expStep;
   } vec_t;

   vec_t vecs[9];
   vec_t expQ[$];

   riscv_test_monitor #(
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT),
      .DONE_REG      (26),
      .RESULT_REG    (27),
      .TESTNUM_REG   (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_we    (wb_we),
      .wb_waddr (wb_waddr),
      .wb_wdata (wb_wdata),
      .done     (done),
      .pass     (pass),
      .fail     (fail),
      .timeout  (timeout),
      .test_num (test_num),
      .cycle_cnt(cycle_cnt)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL vec%0d %s: got %0h expected %0h", curVec, name, act, exp);
      end
   endtask

   // Drive one write-back cycle and return just after the clock edge.
   task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data);
      wb_we    = we;
      wb_waddr = addr;
      wb_wdata = data;
      @(posedge clk);
      #1;
      wb_we    = 1'b0;
      wb_waddr = 5'd0;
      wb_wdata = 32'd0;
   endtask

   // Assert reset, confirm every output clears, then release on a falling edge.
   task automatic doReset();
      rst      = 1'b1;
      wb_we    = 1'b0;
      wb_waddr = 5'd0;
      wb_wdata = 32'd0;
      #2;
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstPass", {31'd0, pass}, 32'd0);
      checkOutput("rstFail", {31'd0, fail}, 32'd0);
      checkOutput("rstTimeout", {31'd0, timeout}, 32'd0);
      checkOutput("rstTestNum", test_num, 32'd0);
      checkOutput("rstCycleCnt", cycle_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Run one scenario vector to completion and score it.
   task automatic runVector(input vec_t v, input bit withReset);
      vec_t exp;
      int   doneStep;
      logic we;
      logic [4:0] a;
      logic [31:0] d;
      if (withReset) doReset();
      expQ.push_back(v);
      doneStep = 0;
      for (int s = 1; s <= MAX_STEPS && doneStep == 0; s++) begin
         we = 1'b0; a = 5'd0; d = 32'd0;
         if (s == 2) begin
            we = 1'b1; a = 5'd3; d = v.testNum;
         end else if (s == 3) begin
            we = 1'b1; a = 5'd27; d = v.earlyRes;
         end else if (v.doDone && s == v.doneStep) begin
            we = 1'b1; a = 5'd26; d = 32'd1;
         end else if (v.doDone && v.lateOff != 0 && s == v.doneStep + v.lateOff) begin
            we = 1'b1; a = 5'd27; d = v.lateVal;
         end
         applyStimulus(we, a, d);
         if (done) doneStep = s;
      end
      exp = expQ.pop_front();
      checkOutput("doneStep", doneStep, exp.expStep);
      checkOutput("pass", {31'd0, pass}, {31'd0, exp.expPass});
      checkOutput("fail", {31'd0, fail}, {31'd0, exp.expFail});
      checkOutput("timeout", {31'd0, timeout}, {31'd0, exp.expTimeout});
      checkOutput("testNum", test_num, exp.testNum);
      checkOutput("cycleCnt", cycle_cnt, exp.expStep);
      // Terminal state must ignore further writes of every kind.
      applyStimulus(1'b1, 5'd3, 32'd99);
      applyStimulus(1'b1, 5'd27, exp.expPass ? 32'd0 : 32'd1);
      applyStimulus(1'b1, 5'd26, 32'd1);
      checkOutput("stickyDone", {31'd0, done}, 32'd1);
      checkOutput("stickyPass", {31'd0, pass}, {31'd0, exp.expPass});
      checkOutput("stickyFail", {31'd0, fail}, {31'd0, exp.expFail});
      checkOutput("stickyTimeout", {31'd0, timeout}, {31'd0, exp.expTimeout});
      checkOutput("stickyTestNum", test_num, exp.testNum);
      checkOutput("stickyCycleCnt", cycle_cnt, exp.expStep);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      curVec = 0;
      rst = 1'b1;
      wb_we = 1'b0;
      wb_waddr = 5'd0;
      wb_wdata = 32'd0;

      // testNum earlyRes doDone doneStep lateOff lateVal P F T expStep
      vecs[0] = '{5,  1, 1'b1, 41, 0,  0, 1'b1, 1'b0, 1'b0, 51};
      vecs[1] = '{7,  0, 1'b1, 20, 0,  0, 1'b0, 1'b1, 1'b0, 30};
      vecs[2] = '{9,  0, 1'b1, 20, 3,  1, 1'b1, 1'b0, 1'b0, 30};
      vecs[3] = '{11, 0, 1'b1, 20, 10, 1, 1'b1, 1'b0, 1'b0, 30};
      vecs[4] = '{12, 1, 1'b1, 25, 10, 0, 1'b0, 1'b1, 1'b0, 35};
      vecs[5] = '{13, 1, 1'b0, 0,  0,  0, 1'b0, 1'b0, 1'b1, 50};
      vecs[6] = '{14, 1, 1'b1, 50, 0,  0, 1'b1, 1'b0, 1'b0, 60};
      vecs[7] = '{15, 2, 1'b1, 49, 0,  0, 1'b0, 1'b1, 1'b0, 59};
      vecs[8] = '{16, 1, 1'b1, 20, 9,  0, 1'b0, 1'b1, 1'b0, 30};

      for (int i = 0; i < 9; i++) begin
         curVec = i;
         runVector(vecs[i], 1'b1);
      end

      // Writes that must not end the test: wrong value, x0, disabled enable.
      curVec = 100;
      doReset();
      applyStimulus(1'b1, 5'd26, 32'd2);
      applyStimulus(1'b1, 5'd0, 32'd1);
      applyStimulus(1'b0, 5'd26, 32'd1);
      applyStimulus(1'b1, 5'd26, 32'hFFFF_FFFF);
      checkOutput("ignCycleCnt", cycle_cnt, 32'd4);
      for (int s = 5; s <= 20; s++) applyStimulus(1'b0, 5'd0, 32'd0);
      checkOutput("ignDoneStep20", {31'd0, done}, 32'd0);
      for (int s = 21; s <= 49; s++) applyStimulus(1'b0, 5'd0, 32'd0);
      checkOutput("ignDoneStep49", {31'd0, done}, 32'd0);
      applyStimulus(1'b0, 5'd0, 32'd0);
      checkOutput("ignTimeout", {31'd0, timeout}, 32'd1);
      checkOutput("ignCycleCntFrozen", cycle_cnt, 32'd50);

      // Reset four cycles into the settle window, then a fresh run.
      curVec = 101;
      doReset();
      applyStimulus(1'b0, 5'd0, 32'd0);
      applyStimulus(1'b1, 5'd3, 32'd21);
      applyStimulus(1'b1, 5'd27, 32'd1);
      for (int s = 4; s <= 9; s++) applyStimulus(1'b0, 5'd0, 32'd0);
      applyStimulus(1'b1, 5'd26, 32'd1);
      for (int s = 11; s <= 14; s++) applyStimulus(1'b0, 5'd0, 32'd0);
      checkOutput("preAbortTestNum", test_num, 32'd21);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abortDone", {31'd0, done}, 32'd0);
      checkOutput("abortTestNum", test_num, 32'd0);
      checkOutput("abortCycleCnt", cycle_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      curVec = 102;
      runVector(vecs[2], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got hang expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
